// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter and its round-robin core.
package data_mem_arb_pkg;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef enum logic {IDLE, CLEAR} arb_state_t;
  typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the port not granted last wins; the
// pointer only moves when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt != 2'b00) begin
      last_d = gnt[1];
    end
  end

  // last = 1 out of reset so port 0 takes the first tie
  always_ff @(posedge clk) begin
    if (srst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between two requesters and provides a
// whole-memory clear sequencer that pre-empts normal traffic.
module data_mem_arbiter #(
  parameter int AW    = data_mem_arb_pkg::AW,
  parameter int DW    = data_mem_arb_pkg::DW,
  parameter int DEPTH = 256
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          We0,
  input  logic          We1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Wdata0,
  input  logic [DW-1:0] Wdata1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          Rvalid0,
  output logic          Rvalid1,
  output logic [DW-1:0] Rdata0,
  output logic [DW-1:0] Rdata1,
  input  logic          ClearStart,
  input  logic [DW-1:0] ClearVal,
  output logic          ClearBusy,
  output logic          ClearDone,
  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut
);

  import data_mem_arb_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  arb_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] clr_val_q, clr_val_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          clear_done_q, clear_done_d;

  logic       arb_en;
  logic [1:0] gnt;

  // Arbitration only runs in IDLE when no clear is being launched
  assign arb_en = !Reset && (state_q == IDLE) && !ClearStart;

  rr_arb2 u_rr_arb2 (
    .clk  (CLK),
    .srst (Reset),
    .en   (arb_en),
    .req  ({Req1, Req0}),
    .gnt  (gnt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_val_d    = clr_val_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    clear_done_d = 1'b0;
    DataAddress  = '0;
    DataIn       = '0;
    ReadMem      = 1'b0;
    WriteMem     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ClearStart) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          clr_val_d = ClearVal;
        end else if (gnt[0]) begin
          DataAddress = Addr0;
          DataIn      = We0 ? Wdata0 : '0;
          WriteMem    = We0;
          ReadMem     = !We0;
          rvalid0_d   = !We0;
          if (!We0) rdata0_d = DataOut;
        end else if (gnt[1]) begin
          DataAddress = Addr1;
          DataIn      = We1 ? Wdata1 : '0;
          WriteMem    = We1;
          ReadMem     = !We1;
          rvalid1_d   = !We1;
          if (!We1) rdata1_d = DataOut;
        end
      end
      CLEAR: begin
        DataAddress = cnt_q;
        DataIn      = clr_val_q;
        WriteMem    = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d      = IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over everything, including an in-flight clear write
    if (Reset) begin
      ReadMem  = 1'b0;
      WriteMem = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clr_val_q    <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_val_q    <= clr_val_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign Gnt0      = gnt[0];
  assign Gnt1      = gnt[1];
  assign Rvalid0   = rvalid0_q;
  assign Rvalid1   = rvalid1_q;
  assign Rdata0    = rdata0_q;
  assign Rdata1    = rdata1_q;
  assign ClearBusy = (state_q == CLEAR);
  assign ClearDone = clear_done_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a behavioural memory sits behind the DUT, a
// reference model predicts grants and read data, and a monitor drains a scoreboard.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Req0, Req1, We0, We1;
  logic [7:0] Addr0, Addr1, Wdata0, Wdata1;
  logic       Gnt0, Gnt1, Rvalid0, Rvalid1;
  logic [7:0] Rdata0, Rdata1;
  logic       ClearStart;
  logic [7:0] ClearVal;
  logic       ClearBusy, ClearDone;
  logic [7:0] DataAddress;
  logic       ReadMem, WriteMem;
  logic [7:0] DataIn, DataOut;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .CLK(clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Rvalid0(Rvalid0), .Rvalid1(Rvalid1),
    .Rdata0(Rdata0), .Rdata1(Rdata1),
    .ClearStart(ClearStart), .ClearVal(ClearVal),
    .ClearBusy(ClearBusy), .ClearDone(ClearDone),
    .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  // The memory itself: combinational read, write on posedge
  logic [7:0] mem [256];
  assign DataOut = mem[DataAddress];
  always @(posedge clk) if (WriteMem) mem[DataAddress] <= DataIn;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0] ref_mem [256];
  int         last_g = 1;
  bit         m_clear = 0;
  int         m_cnt = 0;
  logic [7:0] m_val = '0;
  bit         m_done = 0;
  logic [7:0] q0[$], q1[$];

  // Requesters: a request stays armed until its grant is seen
  bit         p_req [2];
  bit         p_we  [2];
  logic [7:0] p_addr[2];
  logic [7:0] p_wd  [2];

  task automatic arm(input int p, input bit we, input logic [7:0] a, input logic [7:0] d);
    p_req[p] = 1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
  endtask

  // One clock cycle: called just after a negedge, returns at the next negedge
  task automatic step();
    bit e0, e1, wm, rm, g0, g1, nd;
    int ea, ed;
    Req0 = p_req[0]; We0 = p_we[0]; Addr0 = p_addr[0]; Wdata0 = p_wd[0];
    Req1 = p_req[1]; We1 = p_we[1]; Addr1 = p_addr[1]; Wdata1 = p_wd[1];
    #1;
    e0 = 0; e1 = 0; wm = 0; rm = 0; ea = -1; ed = -1;
    if (Reset) begin
      // nothing may happen
    end else if (m_clear) begin
      wm = 1; ea = m_cnt; ed = m_val;
    end else if (!ClearStart) begin
      if (Req0 && Req1) begin
        e0 = (last_g == 1); e1 = !e0;
      end else begin
        e0 = Req0; e1 = Req1;
      end
      if (e0) begin wm = We0; rm = !We0; ea = Addr0; if (We0) ed = Wdata0; end
      if (e1) begin wm = We1; rm = !We1; ea = Addr1; if (We1) ed = Wdata1; end
    end
    chk("gnt0", Gnt0, e0);
    chk("gnt1", Gnt1, e1);
    chk("write_mem", WriteMem, wm);
    chk("read_mem", ReadMem, rm);
    chk("clear_busy", ClearBusy, m_clear);
    chk("clear_done", ClearDone, m_done);
    if (ea >= 0) chk("data_address", DataAddress, ea);
    if (ed >= 0) chk("data_in", DataIn, ed);
    g0 = Gnt0; g1 = Gnt1;
    @(posedge clk);
    nd = 0;
    if (Reset) begin
      m_clear = 0; last_g = 1;
    end else if (m_clear) begin
      ref_mem[m_cnt] = m_val;
      if (m_cnt == 255) begin m_clear = 0; nd = 1; end
      else m_cnt++;
    end else if (ClearStart) begin
      m_clear = 1; m_cnt = 0; m_val = ClearVal;
    end else if (e0 || e1) begin
      if (e0) begin
        if (We0) ref_mem[Addr0] = Wdata0; else q0.push_back(ref_mem[Addr0]);
        last_g = 0;
      end else begin
        if (We1) ref_mem[Addr1] = Wdata1; else q1.push_back(ref_mem[Addr1]);
        last_g = 1;
      end
    end
    m_done = nd;
    if (g0) p_req[0] = 0;
    if (g1) p_req[1] = 0;
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((p_req[0] || p_req[1]) && n < max) begin step(); n++; end
    if (p_req[0] || p_req[1]) chk({name, "_timeout"}, 1, 0);
    step(); step();
  endtask

  task automatic clear_run(input logic [7:0] v, input int cycles);
    ClearStart = 1; ClearVal = v;
    step();
    ClearStart = 0; ClearVal = 8'h00;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Scoreboard monitor: every read grant must yield exactly one Rvalid next cycle
  initial begin
    forever begin
      @(posedge clk); #2;
      if (Rvalid0) begin
        if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
        else chk("rdata0", Rdata0, q0.pop_front());
      end else if (q0.size() != 0) begin
        chk("rvalid0_missing", 0, 1); void'(q0.pop_front());
      end
      if (Rvalid1) begin
        if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
        else chk("rdata1", Rdata1, q1.pop_front());
      end else if (q1.size() != 0) begin
        chk("rvalid1_missing", 0, 1); void'(q1.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    for (int p = 0; p < 2; p++) begin p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0; end
    Reset = 1; ClearStart = 0; ClearVal = 0;
    @(negedge clk);
    // Requests under reset must not be granted
    arm(0, 0, 8'h00, 8'h00);
    step(); step();
    chk("reset_rvalid0", Rvalid0, 0);
    chk("reset_rvalid1", Rvalid1, 0);
    chk("reset_rdata0", Rdata0, 0);
    chk("reset_rdata1", Rdata1, 0);
    p_req[0] = 0;
    Reset = 0;
    step();

    // 1: write then read on port 0
    arm(0, 1, 8'h10, 8'h5A); drain("t1w", 4);
    arm(0, 0, 8'h10, 8'h00); drain("t1r", 4);

    // 2: contended reads, grants alternate starting with port 0
    arm(1, 1, 8'h01, 8'hA1); drain("t2a", 4);
    arm(1, 1, 8'h02, 8'hB2); drain("t2b", 4);
    for (int i = 0; i < 4; i++) begin
      if (!p_req[0]) arm(0, 0, 8'h01, 8'h00);
      if (!p_req[1]) arm(1, 0, 8'h02, 8'h00);
      step();
    end
    drain("t2", 4);

    // 3+4: clear with port 1 waiting; grant lands in the ClearDone cycle
    arm(1, 0, 8'h10, 8'h00);
    ClearStart = 1; ClearVal = 8'hFF;
    step();
    ClearStart = 0; ClearVal = 8'h00;
    drain("t4", 300);
    arm(0, 0, 8'h00, 0); drain("t3a", 4);
    arm(0, 0, 8'h7F, 0); drain("t3b", 4);
    arm(0, 0, 8'hFF, 0); drain("t3c", 4);

    // 5: reset in the cycle where the clear counter is 100
    clear_run(8'h3C, 100);
    Reset = 1; step();
    Reset = 0; step(); step();
    arm(0, 0, 8'd99, 0);  drain("t5a", 4);
    arm(0, 0, 8'd100, 0); drain("t5b", 4);

    // 6: write on port 0 then read by port 1 the very next cycle
    step();
    arm(0, 1, 8'h20, 8'h11); step();
    arm(1, 0, 8'h20, 8'h00); drain("t6", 4);

    // Random traffic on a small address window to provoke collisions
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 3) != 0)
          arm(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      ClearStart = (i == 300);
      ClearVal   = 8'($urandom);
      step();
    end
    ClearStart = 0;
    drain("rand", 300);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
